// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_scheduler : round-robin sharing of one UART transmitter among NREQ
// byte producers. Optional inter-frame gap: define UART_SCHED_GAP_EN.
// Revision 1.0
// ----------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int NREQ         = 4,
  parameter int BUSY_TIMEOUT = 16,
  parameter int GAP_CYCLES   = 104
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_i,
  input  logic [8*NREQ-1:0]       req_data_i,
  output logic [NREQ-1:0]         ack_o,
  output logic                    tx_start_o,
  output logic [7:0]              tx_data_o,
  input  logic                    tx_busy_i,
  output logic [$clog2(NREQ)-1:0] grant_idx_o,
  output logic                    active_o,
  output logic                    err_o
);

  localparam int IDXW    = $clog2(NREQ);
  localparam int CW      = IDXW + 1;
  localparam int CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [IDXW-1:0]   grant_q, grant_d;
  logic              err_q, err_d;

  logic              w_found;
  logic [IDXW-1:0]   w_gidx;
  logic [CW-1:0]     w_cand;
  logic [7:0]        w_byte;

  // Rotating priority: search starts one past the last grant and wraps.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = grant_q;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = {1'b0, grant_q} + CW'(k);
      if (w_cand >= CW'(NREQ)) begin
        w_cand = w_cand - CW'(NREQ);
      end
      if (!w_found && req_i[w_cand[IDXW-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_cand[IDXW-1:0];
      end
    end
  end

  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gidx == IDXW'(i)) begin
        w_byte = req_data_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        // A busy line in IDLE belongs to someone else; hold off the grant.
        if (w_found && !tx_busy_i) begin
          tx_data_d      = w_byte;
          grant_d        = w_gidx;
          ack_d[w_gidx]  = 1'b1;
          tx_start_d     = 1'b1;
          cnt_d          = '0;
          state_d        = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy_i) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_q == CNTW'(BUSY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy_i) begin
`ifdef UART_SCHED_GAP_EN
          // The cycle that sees busy fall is the first idle-line cycle.
          cnt_d   = CNTW'(1);
          state_d = GAP;
`else
          state_d = IDLE;
`endif
        end
      end
      GAP: begin
`ifdef UART_SCHED_GAP_EN
        if (cnt_q >= CNTW'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      grant_q    <= IDXW'(NREQ - 1);
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
    end
  end

  assign ack_o       = ack_q;
  assign tx_start_o  = tx_start_q;
  assign tx_data_o   = tx_data_q;
  assign grant_idx_o = grant_q;
  assign active_o    = (state_q != IDLE);
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART transmitter between NREQ byte-producing requesters.
- Round-robin arbitration: one granted byte per frame.
- Drives the transmitter's start strobe and data bus, then tracks its busy flag until the frame completes.
- Sits between requester logic (debounced buttons, status/report generators) and the transmitter in the top level.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- BUSY_TIMEOUT, 16, cycles allowed after tx_start for tx_busy to rise before the frame is abandoned.
- GAP_CYCLES, 104, idle cycles inserted between frames (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  NREQ  level request per requester; held until its ack.
- req_data  in  8*NREQ  flat byte bus; requester i occupies bits [8i+7:8i]; stable while req[i]=1.
- ack  out  NREQ  one-cycle pulse; byte of the indicated requester captured.
- tx_start  out  1  one-cycle start strobe to the transmitter.
- tx_data  out  8  byte to the transmitter; held stable from tx_start until the frame ends.
- tx_busy  in  1  transmitter busy flag.
- grant_idx  out  clog2(NREQ)  index of the last/current granted requester.
- active  out  1  high while a frame is owned (states other than IDLE).
- err  out  1  sticky flag: busy timeout occurred; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE; ack=0, tx_start=0, tx_data=0, active=0, err=0.
  - grant_idx=NREQ-1, so requester 0 has first priority.
  - timeout/gap counters=0.
- IDLE:
  - If req != 0, choose g = first set bit searching (grant_idx+1) mod NREQ upward with wrap.
  - At that edge: tx_data<=req_data[g], grant_idx<=g, ack[g]<=1, tx_start<=1, go to WAIT_BUSY.
  - ack and tx_start are both high exactly in the cycle after req is sampled: latency 1 cycle from req to ack/tx_start.
- WAIT_BUSY:
  - ack and tx_start return to 0 after one cycle.
  - Counter increments each cycle.
  - If tx_busy=1, go to WAIT_DONE and clear the counter.
  - If the counter reaches BUSY_TIMEOUT with tx_busy still 0: set err=1, go to IDLE; the byte is dropped and is not retried.
- WAIT_DONE: hold tx_data; on tx_busy=0, go to IDLE (or GAP with the feature enabled).
- Requesters:
  - Must deassert req in the cycle after ack, or keep it high to queue another byte.
  - A requester keeping req high is re-granted only after every other active requester has been served once.
- req changes outside IDLE are ignored; no preemption.
- Simultaneous req of all NREQ with continuous demand → grant order 0,1,...,NREQ-1,0,...
- A single requester with continuous req is granted back-to-back; one frame per IDLE visit, so 1 IDLE cycle between frames.
- tx_busy already high in IDLE (foreign owner) → treat as not ready; no grant until tx_busy=0.
- active=1 in WAIT_BUSY, WAIT_DONE and GAP.

Optional Feature:
- Macro: UART_SCHED_GAP_EN.
- Defined:
  - WAIT_DONE goes to GAP on tx_busy falling.
  - GAP counts GAP_CYCLES cycles with no grant, then goes to IDLE.
  - Guarantees at least GAP_CYCLES idle line time between frames.
- Undefined: no GAP state; WAIT_DONE → IDLE directly; GAP_CYCLES unused.

Test Plan:
- Single request: req=0001, req_data[7:0]=0x41, transmitter model busy 3 cycles after start for 20 cycles.
  - ack[0] and tx_start pulse one cycle after req; tx_data=0x41 held until busy falls; active falls next cycle; err=0.
- Contention: req=0101 together, bytes 0x11 (req0) and 0x33 (req2), each dropped after ack.
  - First frame 0x11 with grant_idx=0, second frame 0x33 with grant_idx=2.
- Continuous all four, bytes 0xA0..0xA3.
  - Frame order A0,A1,A2,A3,A0; exactly one ack per frame.
- Timeout: transmitter never raises busy, req=0010.
  - After BUSY_TIMEOUT cycles: err=1, state IDLE, next request still served, err stays 1.
- Reset mid-frame: rst_n low during WAIT_DONE.
  - All outputs 0 immediately (async), grant_idx=NREQ-1; after release, requester 0 wins a 1111 request.
- With UART_SCHED_GAP_EN, GAP_CYCLES=10: two back-to-back frames from requester 1.
  - Exactly 10 cycles with tx_busy=0 and active=1 between busy fall and the second tx_start, plus 1 IDLE cycle.
